hsp_drain: RTL and testbench

//  Read side of the HSP FIFO. Pops HSP records {s,q,l,score} and drops records

---
 rtl/hsp_drain.sv | 139 +++++++++++++
 tb/tb_hsp_drain.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsp_drain.sv
// HSP FIFO read side: pops records, filters on l/score, packs survivors into a
// valid/ready word stream and closes batches with a count trailer. Define HSP_DRAIN_STATS_EN for drop/max-score stats.
module hsp_drain #(
   parameter int                 FIELD_W     = 8,
   parameter logic [FIELD_W-1:0] TRAILER_TAG = 8'hFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   drain_en,
   input  logic [FIELD_W-1:0]     score_min,
   input  logic                   flush_req,
   input  logic                   buf_empty,
   input  logic [FIELD_W-1:0]     buf_out_s,
   input  logic [FIELD_W-1:0]     buf_out_q,
   input  logic [FIELD_W-1:0]     buf_out_l,
   input  logic [FIELD_W-1:0]     buf_out_score,
   output logic                   rd_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*FIELD_W-1:0]   out_data,
   output logic                   out_last,
   output logic [3*FIELD_W-1:0]   hsp_cnt,
   output logic                   busy
`ifdef HSP_DRAIN_STATS_EN
   ,
   output logic [15:0]            drop_cnt,
   output logic [FIELD_W-1:0]     max_score
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_SEND,
      S_TRAIL
   } state_t;

   state_t state;
   logic   flush_pend;

   function automatic logic [3*FIELD_W-1:0] sat_inc_cnt(input logic [3*FIELD_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A record survives only with a non-zero length and a score at or above the threshold.
   function automatic logic keep_rec(input logic [FIELD_W-1:0] l,
                                     input logic [FIELD_W-1:0] sc,
                                     input logic [FIELD_W-1:0] smin);
      return (l != '0) && (sc >= smin);
   endfunction

   assign busy = (state != S_IDLE) || flush_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rd_en      <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         hsp_cnt    <= '0;
         flush_pend <= 1'b0;
`ifdef HSP_DRAIN_STATS_EN
         drop_cnt   <= '0;
         max_score  <= '0;
`endif
      end else begin
         if (flush_req)
            flush_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               // The trailer wins over a new pop so a drained batch closes promptly.
               if (flush_pend && buf_empty) begin
                  state     <= S_TRAIL;
                  out_valid <= 1'b1;
                  out_last  <= 1'b1;
                  out_data  <= {TRAILER_TAG, hsp_cnt};
               end else if (drain_en && !buf_empty) begin
                  state <= S_POP;
                  rd_en <= 1'b1;
               end
            end
            S_POP: begin
               rd_en <= 1'b0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               out_data <= {buf_out_score, buf_out_l, buf_out_q, buf_out_s};
               if (keep_rec(buf_out_l, buf_out_score, score_min)) begin
                  state     <= S_SEND;
                  out_valid <= 1'b1;
               end else begin
                  state <= S_IDLE;
`ifdef HSP_DRAIN_STATS_EN
                  drop_cnt <= sat_inc_16(drop_cnt);
`endif
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  hsp_cnt   <= sat_inc_cnt(hsp_cnt);
`ifdef HSP_DRAIN_STATS_EN
                  if (out_data[4*FIELD_W-1:3*FIELD_W] > max_score)
                     max_score <= out_data[4*FIELD_W-1:3*FIELD_W];
`endif
               end
            end
            S_TRAIL: begin
               if (out_ready) begin
                  state      <= S_IDLE;
                  out_valid  <= 1'b0;
                  out_last   <= 1'b0;
                  hsp_cnt    <= '0;
                  // A flush arriving with this handshake opens the next batch's request.
                  flush_pend <= flush_req;
               end
            end
            default: begin
               state <= S_IDLE;
               rd_en <= 1'b0;
            end
         endcase
      end
   end

`ifndef HSP_DRAIN_STATS_EN
   function automatic logic unused_sat16(input logic [15:0] v);
      return ^sat_inc_16(v);
   endfunction
`endif

endmodule

// File: tb/tb_hsp_drain.sv
// Scoreboard bench for hsp_drain: FIFO model, behavioural filter/count model,
// directed scenarios followed by randomized batches.
module tb_hsp_drain;

   localparam int FW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            drain_en;
   logic [FW-1:0]   score_min;
   logic            flush_req;
   logic            buf_empty;
   logic [FW-1:0]   buf_out_s, buf_out_q, buf_out_l, buf_out_score;
   logic            rd_en;
   logic            out_valid;
   logic            out_ready;
   logic [4*FW-1:0] out_data;
   logic            out_last;
   logic [3*FW-1:0] hsp_cnt;
   logic            busy;
`ifdef HSP_DRAIN_STATS_EN
   logic [15:0]     drop_cnt;
   logic [FW-1:0]   max_score;
`endif

   always #5 clk = ~clk;

   hsp_drain #(.FIELD_W(FW), .TRAILER_TAG(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .score_min(score_min),
      .flush_req(flush_req), .buf_empty(buf_empty),
      .buf_out_s(buf_out_s), .buf_out_q(buf_out_q), .buf_out_l(buf_out_l),
      .buf_out_score(buf_out_score), .rd_en(rd_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .hsp_cnt(hsp_cnt), .busy(busy)
`ifdef HSP_DRAIN_STATS_EN
      , .drop_cnt(drop_cnt), .max_score(max_score)
`endif
   );

   typedef struct packed {
      logic [7:0] s;
      logic [7:0] q;
      logic [7:0] l;
      logic [7:0] sc;
   } rec_t;

   int          checks = 0;
   int          errors = 0;
   rec_t        fifo_q[$];
   logic [32:0] exp_q[$];
   logic [32:0] exp_e;
   rec_t        pop_r;
   int          pop_cnt = 0;
   logic [31:0] last_word = '0;
   logic [23:0] model_cnt = '0;
   int          model_drop = 0;
   logic [7:0]  model_max = '0;
   bit          rand_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference: a record is forwarded iff l is non-zero and score >= threshold.
   task automatic push_rec(input logic [7:0] s, input logic [7:0] q,
                           input logic [7:0] l, input logic [7:0] sc);
      fifo_q.push_back({s, q, l, sc});
      buf_empty = 1'b0;
      if (l != 0 && sc >= score_min) begin
         exp_q.push_back({1'b0, sc, l, q, s});
         if (model_cnt != 24'hFFFFFF) model_cnt = model_cnt + 1;
         if (sc > model_max) model_max = sc;
      end else if (model_drop < 65535) begin
         model_drop++;
      end
   endtask

   task automatic push_trailer();
      exp_q.push_back({1'b1, 8'hFF, model_cnt});
      model_cnt = '0;
   endtask

   task automatic do_flush();
      flush_req = 1'b1;
      push_trailer();
      @(posedge clk);
      #2;
      flush_req = 1'b0;
   endtask

   task automatic wait_drained(input string name, input int budget);
      int n = 0;
      while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s drain_timeout actual=pending(%0d words) required=idle", name, exp_q.size());
      end
   endtask

   task automatic wait_valid(input string name, input bit want_last, input int budget);
      int n = 0;
      while (!(out_valid && (out_last == want_last)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s valid_timeout actual=out_valid=%b required=1", name, out_valid);
      end
   endtask

   // FIFO model: data appears in the cycle after the pop strobe.
   always @(negedge clk) begin
      if (rst_n && rd_en) begin
         checks++;
         if (fifo_q.size() == 0) begin
            errors++;
            $display("FAIL fifo_overread actual=rd_en=1 required=no pop on empty FIFO");
         end else begin
            pop_r = fifo_q.pop_front();
            buf_out_s = pop_r.s;
            buf_out_q = pop_r.q;
            buf_out_l = pop_r.l;
            buf_out_score = pop_r.sc;
            pop_cnt++;
         end
         buf_empty = (fifo_q.size() == 0);
      end
   end

   // Scoreboard monitor: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_word actual=%h last=%b required=no word", out_data, out_last);
         end else begin
            exp_e = exp_q.pop_front();
            if ({out_last, out_data} !== exp_e) begin
               errors++;
               $display("FAIL stream_word actual=%h last=%b required=%h last=%b",
                        out_data, out_last, exp_e[31:0], exp_e[32]);
            end
         end
         last_word = out_data;
      end
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #2;
         if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drain_en  = ($urandom_range(0, 4) != 0);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nrec;
      rst_n = 1'b0; drain_en = 1'b1; score_min = 8'd5; flush_req = 1'b0;
      buf_empty = 1'b1; out_ready = 1'b1;
      buf_out_s = '0; buf_out_q = '0; buf_out_l = '0; buf_out_score = '0;
      tick(3);
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_hsp_cnt", {8'd0, hsp_cnt}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // One record: pop strobe, then the word three cycles after the FIFO goes non-empty.
      push_rec(8'd1, 8'd2, 8'd3, 8'd9);
      @(negedge clk);
      @(negedge clk); chk("one_rd_en_hi", {31'd0, rd_en}, 32'd1);
      @(negedge clk); chk("one_rd_en_lo", {31'd0, rd_en}, 32'd0);
      chk("one_no_early_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("one_valid", {31'd0, out_valid}, 32'd1);
      chk("one_data", out_data, 32'h09030201);
      @(negedge clk); chk("one_hsp_cnt", {8'd0, hsp_cnt}, 32'd1);
      tick(1);

      // Asynchronous reset while a word waits in SEND.
      out_ready = 1'b0;
      push_rec(8'd7, 8'd7, 8'd7, 8'd77);
      wait_valid("rst_mid_send", 1'b0, 20);
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("arst_hsp_cnt", {8'd0, hsp_cnt}, 32'd0);
      exp_q.delete(); fifo_q.delete(); buf_empty = 1'b1;
      model_cnt = '0; model_drop = 0; model_max = '0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("arst_idle_busy", {31'd0, busy}, 32'd0);
      chk("arst_idle_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;

      // Filter: zero length and under-threshold score are both popped and dropped.
      begin
         int p0;
         p0 = pop_cnt;
         push_rec(8'd1, 8'd1, 8'd0, 8'd20);
         push_rec(8'd1, 8'd1, 8'd4, 8'd4);
         wait_drained("filter", 100);
         chk("filter_pops", pop_cnt - p0, 32'd2);
`ifdef HSP_DRAIN_STATS_EN
         chk("filter_drop_cnt", {16'd0, drop_cnt}, model_drop);
`endif
      end
      tick(1);

      // Flush with empty FIFO after three forwarded records.
      push_rec(8'd10, 8'd11, 8'd12, 8'd50);
      push_rec(8'd20, 8'd21, 8'd22, 8'd5);
      push_rec(8'd30, 8'd31, 8'd32, 8'd255);
      wait_drained("flush3_data", 200);
      tick(1);
      do_flush();
      wait_drained("flush3_trailer", 100);
      chk("flush3_word", last_word, 32'hFF000003);
      chk("flush3_hsp_cnt_clr", {8'd0, hsp_cnt}, 32'd0);
      tick(1);

      // Backpressure: the held word stays put and no further pop happens.
      out_ready = 1'b0;
      push_rec(8'd5, 8'd6, 8'd7, 8'd100);
      push_rec(8'd8, 8'd9, 8'd10, 8'd200);
      wait_valid("bp_first", 1'b0, 20);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_data_stable", out_data, 32'h64070605);
         chk("bp_no_rd_en", {31'd0, rd_en}, 32'd0);
      end
      tick(1);
      out_ready = 1'b1;
      wait_drained("bp_release", 100);
      tick(1);
      do_flush();
      wait_drained("bp_trailer", 100);
      chk("bp_trailer_word", last_word, 32'hFF000002);
      tick(1);

      // Flush with two records queued, then a second flush on the trailer handshake.
      push_rec(8'd1, 8'd2, 8'd3, 8'd60);
      push_rec(8'd4, 8'd5, 8'd6, 8'd61);
      do_flush();
      wait_valid("flush2_trailer", 1'b1, 100);
      flush_req = 1'b1;
      push_trailer();
      @(posedge clk);
      #2;
      flush_req = 1'b0;
      chk("flush2_repend_busy", {31'd0, busy}, 32'd1);
      wait_drained("flush2_second", 100);
      chk("flush2_second_word", last_word, 32'hFF000000);
      tick(1);

      // Randomized batches with random stalls and drain gating.
      rand_mode = 1;
      for (int b = 0; b < 40; b++) begin
         score_min = 8'($urandom_range(0, 200));
         nrec = $urandom_range(0, 6);
         for (int r = 0; r < nrec; r++) begin
            push_rec(8'($urandom), 8'($urandom),
                     ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                     8'($urandom));
            tick($urandom_range(1, 3));
         end
         if ($urandom_range(0, 1) == 1) do_flush();
         wait_drained("random_batch", 3000);
         tick(1);
      end
      rand_mode = 0;
      tick(1);
      out_ready = 1'b1;
      drain_en = 1'b1;
      tick(1);
      chk("final_hsp_cnt", {8'd0, hsp_cnt}, {8'd0, model_cnt});
`ifdef HSP_DRAIN_STATS_EN
      chk("final_drop_cnt", {16'd0, drop_cnt}, model_drop);
      chk("final_max_score", {24'd0, max_score}, {24'd0, model_max});
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
